// File: rtl/wshb_arb_pkg.sv
// wshb_arb_pkg: shared constants, state type and index-width helper for the round-robin arbiter
package wshb_arb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  typedef enum logic {IDLE, GRANTED} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wshb_arbiter_rr_if.sv
// wshb_arbiter_rr_if: request/grant bundle between Wishbone masters and the round-robin arbiter
interface wshb_arbiter_rr_if
  import wshb_arb_pkg::*;
#(parameter int NB_MASTERS = 3);
  localparam int IDX_W = idx_w(NB_MASTERS);
  logic [NB_MASTERS-1:0] req;
  logic [NB_MASTERS-1:0] urgent;
  logic                  ack;
  logic [2:0]            cti;
  logic [NB_MASTERS-1:0] grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic                  preempted;
  modport master (output req, urgent, ack, cti, input grant, grant_idx, grant_valid, preempted);
  modport slave  (input req, urgent, ack, cti, output grant, grant_idx, grant_valid, preempted);
endinterface

// File: rtl/wshb_rr_pick.sv
// wshb_rr_pick: round-robin search of a request vector starting just after the last winner
module wshb_rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    onehot = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (int'(last) + k) % N;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = W'(j);
        onehot[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wshb_arbiter_rr.sv
// wshb_arbiter_rr: registered round-robin bus arbiter with ack quota and burst-boundary urgent preemption
module wshb_arbiter_rr
  import wshb_arb_pkg::*;
#(
  parameter int NB_MASTERS = 3,
  parameter int QUANTUM = 64
) (
  input logic clk,
  input logic rst,
  wshb_arbiter_rr_if.slave bus
);
  localparam int IDX_W = idx_w(NB_MASTERS);
  localparam int CNT_W = $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0] QMAX = CNT_W'(QUANTUM);
  state_t                state;
  logic [IDX_W-1:0]      last;
  logic [CNT_W-1:0]      cnt;
  logic [NB_MASTERS-1:0] grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic                  preempted;
  logic [NB_MASTERS-1:0] u_oh, r_oh;
  logic [IDX_W-1:0]      u_idx, r_idx;
  logic                  u_any, r_any;
  logic                  boundary, rel_norm, rel_quota, rel_urg;
  logic [CNT_W-1:0]      cnt_nx;
  wshb_rr_pick #(.N(NB_MASTERS), .W(IDX_W)) u_pick_urg (
    .req(bus.req & bus.urgent), .last(last), .onehot(u_oh), .idx(u_idx), .any(u_any)
  );
  wshb_rr_pick #(.N(NB_MASTERS), .W(IDX_W)) u_pick_req (
    .req(bus.req), .last(last), .onehot(r_oh), .idx(r_idx), .any(r_any)
  );
  always_comb begin
    boundary  = bus.ack && (bus.cti == CTI_CLASSIC || bus.cti == CTI_EOB);
    cnt_nx    = (bus.ack && cnt < QMAX) ? cnt + CNT_W'(1) : cnt;
    rel_norm  = !bus.req[grant_idx];
    rel_quota = boundary && cnt_nx >= QMAX && |(bus.req & ~grant);
    rel_urg   = boundary && !bus.urgent[grant_idx] && |(bus.req & bus.urgent & ~grant);
  end
  // Release always passes through IDLE so the bus sees at least one ownerless cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_idx <= '0;
      grant_valid <= 1'b0;
      preempted <= 1'b0;
      last <= IDX_W'(NB_MASTERS - 1);
      cnt <= '0;
    end else begin
      preempted <= 1'b0;
      if (state == IDLE) begin
        if (r_any) begin
          state <= GRANTED;
          grant <= u_any ? u_oh : r_oh;
          grant_idx <= u_any ? u_idx : r_idx;
          last <= u_any ? u_idx : r_idx;
          grant_valid <= 1'b1;
          cnt <= '0;
        end
      end else begin
        cnt <= cnt_nx;
        if (rel_norm || rel_quota || rel_urg) begin
          state <= IDLE;
          grant <= '0;
          grant_valid <= 1'b0;
          preempted <= !rel_norm;
        end
      end
    end
  end
  assign bus.grant = grant;
  assign bus.grant_idx = grant_idx;
  assign bus.grant_valid = grant_valid;
  assign bus.preempted = preempted;
endmodule

// File: tb/tb_wshb_arbiter_rr.sv
// tb_wshb_arbiter_rr: directed and randomized checks of the round-robin arbiter against an owner-tracking model
module tb_wshb_arbiter_rr;
  localparam int N = 3;
  localparam int Q = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  wshb_arbiter_rr_if #(.NB_MASTERS(N)) bus ();
  wshb_arbiter_rr #(.NB_MASTERS(N), .QUANTUM(Q)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // Reference: who owns the bus, how many acks it has had, and who won last
  int owner, last_w, acks;
  bit pre;
  logic [N-1:0] cand, mine;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner = -1;
      last_w = N - 1;
      acks = 0;
      pre = 0;
    end else if (owner < 0) begin
      pre = 0;
      cand = ((bus.req & bus.urgent) != 0) ? (bus.req & bus.urgent) : bus.req;
      for (int k = 1; k <= N; k++)
        if (owner < 0 && cand[(last_w + k) % N]) owner = (last_w + k) % N;
      if (owner >= 0) begin
        last_w = owner;
        acks = 0;
      end
    end else begin
      mine = N'(1 << owner);
      if (bus.ack && acks < Q) acks++;
      pre = 0;
      if (!bus.req[owner]) owner = -1;
      else if (bus.ack && (bus.cti == 3'b000 || bus.cti == 3'b111) &&
               ((acks >= Q && (bus.req & ~mine) != 0) ||
                (!bus.urgent[owner] && (bus.req & bus.urgent & ~mine) != 0))) begin
        owner = -1;
        pre = 1;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.grant !== ((owner < 0) ? N'(0) : N'(1 << owner)) || bus.grant_valid !== (owner >= 0) ||
          bus.preempted !== pre || (owner >= 0 && int'(bus.grant_idx) != owner)) begin
        errors++;
        $display("FAIL model t=%0t grant=%b idx=%0d valid=%b pre=%b expected owner=%0d pre=%b",
                 $time, bus.grant, bus.grant_idx, bus.grant_valid, bus.preempted, owner, pre);
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] u, input logic a, input logic [2:0] c);
    bus.req = r;
    bus.urgent = u;
    bus.ack = a;
    bus.cti = c;
    @(negedge clk);
  endtask
  initial begin
    bus.req = '0;
    bus.urgent = '0;
    bus.ack = 1'b0;
    bus.cti = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_grant", int'(bus.grant), 0);
    chk("reset_valid", int'(bus.grant_valid), 0);
    chk("reset_idx", int'(bus.grant_idx), 0);
    chk("reset_pre", int'(bus.preempted), 0);
    step(3'b001, 3'b000, 1'b0, 3'b000);
    chk("latency_grant", int'(bus.grant), 1);
    chk("latency_idx", int'(bus.grant_idx), 0);
    chk("latency_valid", int'(bus.grant_valid), 1);
    chk("latency_pre", int'(bus.preempted), 0);
    for (int g = 1; g <= 3; g++) begin
      repeat (Q) step(3'b111, 3'b000, 1'b1, 3'b000);
      chk("quota_gap_grant", int'(bus.grant), 0);
      chk("quota_gap_pre", int'(bus.preempted), 1);
      step(3'b111, 3'b000, 1'b1, 3'b000);
      chk("quota_next_grant", int'(bus.grant), 1 << (g % N));
      chk("quota_next_pre", int'(bus.preempted), 0);
    end
    step(3'b000, 3'b000, 1'b0, 3'b000);
    chk("drop0_pre", int'(bus.preempted), 0);
    step(3'b010, 3'b000, 1'b0, 3'b000);
    chk("burst_grant1", int'(bus.grant), 2);
    step(3'b010, 3'b000, 1'b1, 3'b010);
    step(3'b111, 3'b100, 1'b0, 3'b010);
    step(3'b111, 3'b100, 1'b1, 3'b010);
    chk("urg_midburst_hold", int'(bus.grant), 2);
    chk("urg_midburst_nopre", int'(bus.preempted), 0);
    step(3'b111, 3'b100, 1'b1, 3'b111);
    chk("urg_eob_grant", int'(bus.grant), 0);
    chk("urg_eob_pre", int'(bus.preempted), 1);
    step(3'b111, 3'b100, 1'b0, 3'b000);
    chk("urg_winner", int'(bus.grant), 4);
    step(3'b010, 3'b000, 1'b0, 3'b000);
    step(3'b010, 3'b000, 1'b0, 3'b000);
    chk("norm_grant1", int'(bus.grant), 2);
    step(3'b000, 3'b000, 1'b0, 3'b000);
    chk("norm_rel_valid", int'(bus.grant_valid), 0);
    chk("norm_rel_pre", int'(bus.preempted), 0);
    step(3'b101, 3'b000, 1'b0, 3'b000);
    chk("norm_next_rr", int'(bus.grant), 4);
    step(3'b010, 3'b000, 1'b0, 3'b000);
    step(3'b010, 3'b000, 1'b0, 3'b000);
    chk("ares_pre_grant", int'(bus.grant), 2);
    #2 rst = 1'b1;
    #1;
    chk("ares_grant", int'(bus.grant), 0);
    chk("ares_valid", int'(bus.grant_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    step(3'b111, 3'b000, 1'b0, 3'b000);
    chk("ares_first", int'(bus.grant), 1);
    for (int i = 0; i < 100; i++) begin
      step(3'b001, 3'b000, 1'b1, 3'b000);
      chk("lone_hold", int'(bus.grant), 1);
    end
    step(3'b011, 3'b000, 1'b1, 3'b000);
    chk("lone_switch_pre", int'(bus.preempted), 1);
    step(3'b011, 3'b000, 1'b0, 3'b000);
    chk("lone_switch_grant", int'(bus.grant), 2);
    for (int i = 0; i < 2000; i++) begin
      logic [2:0] c;
      case ($urandom_range(0, 3))
        0: c = 3'b000;
        1: c = 3'b001;
        2: c = 3'b010;
        default: c = 3'b111;
      endcase
      step(($urandom_range(0, 3) == 0) ? N'($urandom) : (bus.req | N'($urandom_range(0, 1))),
           ($urandom_range(0, 3) == 0) ? N'($urandom) : 3'b000, 1'($urandom), c);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
